// File: rtl/request_conditioner.sv
// request_conditioner: synchronises and debounces car sensor and walk button, and latches walk requests for basic_cycle.
// Ports: clk; reset (async, active-low); raw_sensor, raw_walk (raw inputs); walk_light (walk phase active, from basic_cycle);
//        sensor (debounced car presence); walk (held walk request); walk_queued (press seen during walk phase);
//        press_count (accepted presses, saturating).
module request_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_sensor,
  input  logic             raw_walk,
  input  logic             walk_light,
  output logic             sensor,
  output logic             walk,
  output logic             walk_queued,
  output logic [CNT_W-1:0] press_count
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DW-1:0] CMAX = DW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, PENDING, SERVING, QUEUED} state_t;
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [SYNC_STAGES-1:0] sync_d [2];
  logic [DW-1:0] cnt_q [2];
  logic [DW-1:0] cnt_d [2];
  logic [1:0] raw, syn, stable_q, stable_d;
  logic walk_d1_q, press;
  state_t state_q, state_d;
  logic walk_q, walk_d, queued_q, queued_d;
  logic [CNT_W-1:0] count_q, count_d;
  assign raw = {raw_walk, raw_sensor};
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      syn[i] = sync_q[i][SYNC_STAGES-1];
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw[i]};
      cnt_d[i] = (syn[i] == stable_q[i] || cnt_q[i] == CMAX) ? '0 : cnt_q[i] + 1'b1;
      stable_d[i] = (syn[i] != stable_q[i] && cnt_q[i] == CMAX) ? syn[i] : stable_q[i];
    end
  end
  assign press = stable_q[1] & ~walk_d1_q;
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = press ? PENDING : IDLE;
      PENDING: state_d = walk_light ? SERVING : PENDING;
      SERVING: state_d = walk_light ? (press ? QUEUED : SERVING) : (press ? PENDING : IDLE);
      QUEUED:  state_d = walk_light ? QUEUED : PENDING;
      default: state_d = IDLE;
    endcase
    walk_d = state_d == PENDING;
    queued_d = state_d == QUEUED;
    count_d = (press && !(&count_q)) ? count_q + 1'b1 : count_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      stable_q <= '0;
      walk_d1_q <= 1'b0;
      state_q <= IDLE;
      walk_q <= 1'b0;
      queued_q <= 1'b0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= sync_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      stable_q <= stable_d;
      walk_d1_q <= stable_q[1];
      state_q <= state_d;
      walk_q <= walk_d;
      queued_q <= queued_d;
      count_q <= count_d;
    end
  end
  assign sensor = stable_q[0];
  assign walk = walk_q;
  assign walk_queued = queued_q;
  assign press_count = count_q;
endmodule

// File: tb/tb_request_conditioner.sv
// tb_request_conditioner: directed and random stimulus checked against a behavioural model of request_conditioner.
module tb_request_conditioner;
  localparam int S = 2;
  localparam int D = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic raw_sensor = 1'b1, raw_walk = 1'b1, walk_light = 1'b0;
  logic sensor, walk, walk_queued;
  logic [7:0] press_count;
  int checks = 0, failures = 0;
  request_conditioner #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .raw_sensor(raw_sensor), .raw_walk(raw_walk),
    .walk_light(walk_light), .sensor(sensor), .walk(walk),
    .walk_queued(walk_queued), .press_count(press_count)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, exp);
    end
  endtask
  bit [7:0] hist [2] = '{8'd0, 8'd0};
  bit m_stab [2] = '{1'b0, 1'b0};
  int run [2] = '{0, 0};
  bit m_prev = 1'b0;
  int m_st = 0;
  int m_cnt = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist = '{8'd0, 8'd0};
      m_stab = '{1'b0, 1'b0};
      run = '{0, 0};
      m_prev = 1'b0;
      m_st = 0;
      m_cnt = 0;
    end else begin
      bit p, syn;
      bit r [2];
      r[0] = raw_sensor;
      r[1] = raw_walk;
      p = m_stab[1] && !m_prev;
      if (m_st == 0) m_st = p ? 1 : 0;
      else if (m_st == 1) m_st = walk_light ? 2 : 1;
      else if (m_st == 2) m_st = walk_light ? (p ? 3 : 2) : (p ? 1 : 0);
      else m_st = walk_light ? 3 : 1;
      if (p && m_cnt < 255) m_cnt++;
      m_prev = m_stab[1];
      for (int i = 0; i < 2; i++) begin
        syn = hist[i][S-1];
        if (syn == m_stab[i]) run[i] = 0;
        else begin
          run[i]++;
          if (run[i] == D) begin
            m_stab[i] = syn;
            run[i] = 0;
          end
        end
        hist[i] = {hist[i][6:0], r[i]};
      end
    end
  end
  always @(negedge clk) begin
    chk("sensor", 32'(sensor), 32'(m_stab[0]));
    chk("walk", 32'(walk), 32'(m_st == 1));
    chk("walk_queued", 32'(walk_queued), 32'(m_st == 3));
    chk("press_count", 32'(press_count), 32'(m_cnt));
  end
  task automatic press_btn();
    @(negedge clk) raw_walk = 1'b1;
    repeat (6) @(negedge clk);
    raw_walk = 1'b0;
    repeat (6) @(negedge clk);
  endtask
  initial begin
    repeat (3) begin
      @(negedge clk);
      chk("rst_sensor", 32'(sensor), 0);
      chk("rst_walk", 32'(walk), 0);
      chk("rst_queued", 32'(walk_queued), 0);
      chk("rst_count", 32'(press_count), 0);
    end
    raw_sensor = 1'b0;
    raw_walk = 1'b0;
    reset = 1'b1;
    repeat (10) @(negedge clk);
    raw_sensor = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("sensor_edge5", 32'(sensor), 0);
    @(posedge clk);
    #1 chk("sensor_edge6", 32'(sensor), 1);
    @(negedge clk) raw_sensor = 1'b0;
    repeat (12) @(negedge clk);
    raw_sensor = 1'b1;
    repeat (3) @(negedge clk);
    raw_sensor = 1'b0;
    repeat (6) @(negedge clk);
    chk("glitch_mid", 32'(sensor), 0);
    repeat (6) @(negedge clk);
    chk("glitch_end", 32'(sensor), 0);
    raw_walk = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("walk_edge6", 32'(walk), 0);
    @(posedge clk);
    #1 chk("walk_edge7", 32'(walk), 1);
    chk("count_first", 32'(press_count), 1);
    repeat (3) @(negedge clk);
    raw_walk = 1'b0;
    @(negedge clk) walk_light = 1'b1;
    @(posedge clk);
    #1 chk("walk_ack", 32'(walk), 0);
    repeat (10) @(negedge clk);
    raw_walk = 1'b1;
    repeat (7) @(posedge clk);
    #1 chk("queued_set", 32'(walk_queued), 1);
    repeat (3) @(negedge clk);
    raw_walk = 1'b0;
    repeat (10) @(negedge clk);
    walk_light = 1'b0;
    @(posedge clk);
    #1 chk("queued_clr", 32'(walk_queued), 0);
    chk("requeue_walk", 32'(walk), 1);
    repeat (3) press_btn();
    chk("pending_walk", 32'(walk), 1);
    chk("count_five", 32'(press_count), 5);
    repeat (260) press_btn();
    chk("count_sat", 32'(press_count), 255);
    chk("sat_walk", 32'(walk), 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("async_walk", 32'(walk), 0);
    chk("async_count", 32'(press_count), 0);
    @(negedge clk) reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_walk", 32'(walk), 0);
    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(5) == 0) raw_sensor = ~raw_sensor;
      if ($urandom_range(6) == 0) raw_walk = ~raw_walk;
      if ($urandom_range(9) == 0) walk_light = ~walk_light;
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
